// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nibble_add_pkg: shared definitions for the nibble-serial adder controller.
//   NIBBLE_W    - width of the shared adder slice (4 bits)
//   state_t     - controller FSM encoding (IDLE, RUN, DONE)
//   nibbles_of  - number of slice passes needed for a given operand width
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nibbles_of(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: operand/result bus of the nibble-serial adder.
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. The sender holds its payload stable while
//   valid is high and not yet accepted; ready may change freely.
//   master : requester/consumer side (drives in_valid, a, b, cin, out_ready)
//   slave  : controller side (drives in_ready, out_valid, sum, cout, busy,
//            state_dbg)
//   Optional macro SERIAL_ADD_SUBTRACT_EN adds sub (master->slave) and
//   ovf (slave->master).
interface nibble_serial_add_ctrl_if
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  state_t           state_dbg;
`ifdef SERIAL_ADD_SUBTRACT_EN
  logic             sub;
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADD_SUBTRACT_EN
    output sub,
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout, busy, state_dbg
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADD_SUBTRACT_EN
    input  sub,
    output ovf,
`endif
    output in_ready, out_valid, sum, cout, busy, state_dbg
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_slice.sv
// nibble_add_slice: purely combinational 4-bit ripple-carry adder slice.
//   a4, b4 : nibble operands
//   ci     : carry in
//   s4     : nibble sum
//   co     : carry out of bit 3
module nibble_add_slice
  import nibble_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s4   = '0;
    c[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s4[i]   = a4[i] ^ b4[i] ^ c[i];
      c[i+1]  = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
    end
    co = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds WIDTH-bit operands through one shared 4-bit
// slice, one nibble per clock, LSB nibble first, carry held in a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : nibble_serial_add_ctrl_if.slave (operand/result handshakes,
//           busy flag, state_dbg exposing the FSM state)
// Optional macro SERIAL_ADD_SUBTRACT_EN: adds bus.sub (subtract a-b) and
// bus.ovf (two's-complement overflow of the result).
// Timing: accept edge, then NIBBLES RUN edges; out_valid is high after the
// last RUN edge and held until out_ready; new operands only in IDLE.
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
)(
  input  logic                     clk,
  input  logic                     rst_n,
  nibble_serial_add_ctrl_if.slave  bus
);

  localparam int NIBBLES = nibbles_of(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;

  nibble_add_slice u_slice (
    .a4 (a_sh_q[NIBBLE_W-1:0]),
    .b4 (b_sh_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s4 (slice_s),
    .co (slice_co)
  );

  // Subtraction is a + ~b + 1: invert b at latch and force the carry in.
  logic [WIDTH-1:0] b_eff;
  logic             carry_init;
`ifdef SERIAL_ADD_SUBTRACT_EN
  assign b_eff      = bus.sub ? ~bus.b : bus.b;
  assign carry_init = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff      = bus.b;
  assign carry_init = bus.cin;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_sh_d     = bus.a;
          b_sh_d     = b_eff;
          carry_d    = carry_init;
          idx_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        // Each nibble enters at the MSB end; after NIBBLES passes the
        // first nibble has reached bit 0.
        sum_d   = (sum_q >> NIBBLE_W) | (WIDTH'(slice_s) << (WIDTH - NIBBLE_W));
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          cout_d      = slice_co;
          // On the last pass the slice sees the top nibbles, so bit 3 of
          // its operands and result are the word sign bits.
          ovf_d       = (a_sh_q[NIBBLE_W-1] == b_sh_q[NIBBLE_W-1]) &&
                        (slice_s[NIBBLE_W-1] != a_sh_q[NIBBLE_W-1]);
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;
`ifdef SERIAL_ADD_SUBTRACT_EN
  assign bus.ovf       = ovf_q;
`else
  // ovf_q is only observable when subtraction support is built in.
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
